// File: rtl/byte_decode_stream_if.sv
// Byte-in / coefficient-out handshake bundle for the ByteDecode_d stream stage.
// The source of bytes and sink of coefficients drives master; the decoder is slave.
interface byte_decode_stream_if;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] coeff_out;
    logic [7:0]  coeff_idx;
    logic        coeff_valid;
    logic        coeff_ready;

    modport master (
        output in_byte, in_valid, coeff_ready,
        input  in_ready, coeff_out, coeff_idx, coeff_valid
    );

    modport slave (
        input  in_byte, in_valid, coeff_ready,
        output in_ready, coeff_out, coeff_idx, coeff_valid
    );
endinterface

// File: rtl/byte_decode_stream.sv
// Streaming Kyber ByteDecode_d: packs LSB-first bytes into a D+7 bit accumulator
// and emits N_COEFF d-bit coefficients, reduced mod Q when D == 12.
module byte_decode_stream #(
    parameter int D       = 12,
    parameter int N_COEFF = 256,
    parameter int Q       = 3329
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    output logic               busy_o,
    output logic               done_o,
    byte_decode_stream_if.slave bus
);
    localparam int AW = D + 7;
    localparam int CW = $clog2(D + 8);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0] D_C      = CW'(D);
    localparam logic [CW-1:0] BYTE_C   = CW'(8);
    localparam logic [7:0]    LAST_IDX = 8'(N_COEFF - 1);
    localparam logic [11:0]   Q_C      = 12'(Q);

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    idx_q, idx_d;

    logic          in_ready, coeff_valid, in_fire, out_fire;
    logic [11:0]   raw;

    // Ready/valid depend only on registers, so the two sides never fire together.
    assign in_ready    = (state_q == S_RUN) && (cnt_q <  D_C);
    assign coeff_valid = (state_q == S_RUN) && (cnt_q >= D_C);
    assign in_fire     = in_ready && bus.in_valid;
    assign out_fire    = coeff_valid && bus.coeff_ready;

    assign raw = 12'(acc_q[D-1:0]);

    // 4095 < 2Q, so one conditional subtract fully reduces a 12-bit value.
    generate
        if (D == 12) begin : g_reduce
            assign bus.coeff_out = (raw >= Q_C) ? (raw - Q_C) : raw;
        end else begin : g_plain
            assign bus.coeff_out = raw;
        end
    endgenerate

    assign bus.in_ready    = in_ready;
    assign bus.coeff_valid = coeff_valid;
    assign bus.coeff_idx   = idx_q;
    assign busy_o          = (state_q == S_RUN);
    assign done_o          = (state_q == S_DONE);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_RUN;
                    acc_d   = '0;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            S_RUN: begin
                // Bits above cnt are always zero, so OR places the byte at acc[cnt+7:cnt].
                if (in_fire) begin
                    acc_d = acc_q | (AW'(bus.in_byte) << cnt_q);
                    cnt_d = cnt_q + BYTE_C;
                end else if (out_fire) begin
                    acc_d = acc_q >> D;
                    cnt_d = cnt_q - D_C;
                    idx_d = idx_q + 8'd1;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end
endmodule

// File: tb/tb_byte_decode_stream.sv
// Directed and randomised checks of byte_decode_stream for D = 12, 1 and 4,
// using a bit-indexed ByteDecode reference model feeding a scoreboard queue.
module tb_byte_decode_stream;
    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy12, done12, busy1, done1, busy4, done4;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0]  idx;
        logic [11:0] val;
    } exp_t;

    exp_t q12[$];
    exp_t q1[$];
    exp_t q4[$];

    byte_decode_stream_if bus12();
    byte_decode_stream_if bus1();
    byte_decode_stream_if bus4();

    byte_decode_stream #(.D(12), .N_COEFF(256), .Q(3329)) u12 (
        .clk(clk), .rst(rst), .start_i(start), .busy_o(busy12), .done_o(done12), .bus(bus12));
    byte_decode_stream #(.D(1), .N_COEFF(256), .Q(3329)) u1 (
        .clk(clk), .rst(rst), .start_i(start), .busy_o(busy1), .done_o(done1), .bus(bus1));
    byte_decode_stream #(.D(4), .N_COEFF(256), .Q(3329)) u4 (
        .clk(clk), .rst(rst), .start_i(start), .busy_o(busy4), .done_o(done4), .bus(bus4));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference ByteDecode_d: coefficient i takes stream bits i*d .. i*d+d-1.
    function automatic logic [11:0] model(input logic [7:0] b[$], input int d, input int i);
        int v = 0;
        for (int j = 0; j < d; j++) begin
            int p = i * d + j;
            if (b[p / 8][p % 8]) v += (1 << j);
        end
        if (d == 12) v = v % 3329;
        return v[11:0];
    endfunction

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_in_ready"},    {31'd0, bus12.in_ready},    32'd0);
        chk({tag, "_coeff_valid"}, {31'd0, bus12.coeff_valid}, 32'd0);
        chk({tag, "_busy"},        {31'd0, busy12},            32'd0);
        chk({tag, "_done"},        {31'd0, done12},            32'd0);
        chk({tag, "_coeff_out"},   {20'd0, bus12.coeff_out},   32'd0);
        chk({tag, "_coeff_idx"},   {24'd0, bus12.coeff_idx},   32'd0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        chk_zero(tag);
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("start_busy", {31'd0, busy12}, 32'd1);
    endtask

    task automatic stream(input logic [7:0] b[$], input bit rnd, input bit full);
        int   pos = 0;
        int   ncf;
        int   budget = 0;
        bit   fin = 1'b0;
        exp_t e;
        ncf = (b.size() * 8) / 12;
        for (int i = 0; i < ncf; i++) q12.push_back('{idx: 8'(i), val: model(b, 12, i)});
        while (!fin && budget < 5000) begin
            bus12.in_valid    = (pos < b.size()) && (!rnd || $urandom_range(0, 9) < 7);
            bus12.in_byte     = (pos < b.size()) ? b[pos] : 8'h00;
            bus12.coeff_ready = !rnd || ($urandom_range(0, 9) < 7);
            #1;
            chk("excl", {31'd0, bus12.in_ready && bus12.coeff_valid}, 32'd0);
            chk("done_early", {31'd0, done12}, 32'd0);
            if (bus12.coeff_valid && bus12.coeff_ready) begin
                e = q12.pop_front();
                chk("coeff", {20'd0, bus12.coeff_out}, {20'd0, e.val});
                chk("idx",   {24'd0, bus12.coeff_idx}, {24'd0, e.idx});
                if (q12.size() == 0) fin = 1'b1;
            end
            if (bus12.in_valid && bus12.in_ready) pos++;
            cyc();
            budget++;
        end
        bus12.in_valid    = 1'b0;
        bus12.coeff_ready = 1'b0;
        if (!fin) begin
            chk("stream_timeout", 32'd0, 32'd1);
            q12.delete();
        end
        if (full) begin
            chk("done_pulse", {31'd0, done12}, 32'd1);
            chk("done_busy",  {31'd0, busy12}, 32'd0);
            cyc();
            bus12.in_valid = 1'b1;
            bus12.in_byte  = 8'h5A;
            #1;
            chk("done_once",      {31'd0, done12},         32'd0);
            chk("extra_in_ready", {31'd0, bus12.in_ready}, 32'd0);
            chk("idle_busy",      {31'd0, busy12},         32'd0);
            bus12.in_valid = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] b[$];
        logic [7:0] b1[$];
        logic [7:0] b4[$];
        logic [7:0] rnd_frame[$];
        exp_t e;
        int   pos;
        bit   f1, f4;

        rst = 1'b1;
        start = 1'b0;
        bus12.in_valid = 1'b0; bus12.in_byte = 8'h00; bus12.coeff_ready = 1'b0;
        bus1.in_valid  = 1'b0; bus1.in_byte  = 8'h00; bus1.coeff_ready  = 1'b0;
        bus4.in_valid  = 1'b0; bus4.in_byte  = 8'h00; bus4.coeff_ready  = 1'b0;
        @(negedge clk);
        #1;
        chk_zero("reset");
        cyc();
        rst = 1'b0;
        cyc();

        // D=12 basic packing
        pulse_start();
        b = '{8'h01, 8'h23, 8'h45};
        chk("model_c0", {20'd0, model(b, 12, 0)}, 32'h301);
        stream(b, 1'b0, 1'b0);
        chk("refill_ready", {31'd0, bus12.in_ready}, 32'd1);

        // D=12 reduction
        do_reset("rst_a");
        pulse_start();
        b = '{8'hFF, 8'hFF, 8'hFF};
        stream(b, 1'b0, 1'b0);
        do_reset("rst_b");
        pulse_start();
        b = '{8'h01, 8'h0D, 8'h00};
        stream(b, 1'b0, 1'b0);

        // D=1 and D=4 small frames in parallel
        do_reset("rst_c");
        pulse_start();
        b1 = '{8'hA5};
        b4 = '{8'h3C};
        for (int i = 0; i < 8; i++) q1.push_back('{idx: 8'(i), val: model(b1, 1, i)});
        for (int i = 0; i < 2; i++) q4.push_back('{idx: 8'(i), val: model(b4, 4, i)});
        bus1.in_valid = 1'b1; bus1.in_byte = 8'hA5; bus1.coeff_ready = 1'b1;
        bus4.in_valid = 1'b1; bus4.in_byte = 8'h3C; bus4.coeff_ready = 1'b1;
        for (int t = 0; t < 30 && (q1.size() > 0 || q4.size() > 0); t++) begin
            #1;
            f1 = bus1.in_valid && bus1.in_ready;
            f4 = bus4.in_valid && bus4.in_ready;
            if (bus1.coeff_valid && q1.size() > 0) begin
                e = q1.pop_front();
                chk("d1_coeff", {20'd0, bus1.coeff_out}, {20'd0, e.val});
                chk("d1_idx",   {24'd0, bus1.coeff_idx}, {24'd0, e.idx});
            end
            if (bus4.coeff_valid && q4.size() > 0) begin
                e = q4.pop_front();
                chk("d4_coeff", {20'd0, bus4.coeff_out}, {20'd0, e.val});
                chk("d4_idx",   {24'd0, bus4.coeff_idx}, {24'd0, e.idx});
            end
            cyc();
            if (f1) bus1.in_valid = 1'b0;
            if (f4) bus4.in_valid = 1'b0;
        end
        chk("small_timeout", q1.size() + q4.size(), 32'd0);
        bus1.in_valid = 1'b0; bus1.coeff_ready = 1'b0;
        bus4.in_valid = 1'b0; bus4.coeff_ready = 1'b0;

        // Full random D=12 frame with stalls on both sides
        do_reset("rst_d");
        pulse_start();
        for (int i = 0; i < 384; i++) rnd_frame.push_back(8'($urandom_range(0, 255)));
        stream(rnd_frame, 1'b1, 1'b1);

        // Backpressure: coefficient held, start ignored while running
        do_reset("rst_e");
        pulse_start();
        b = '{8'h01, 8'h23};
        pos = 0;
        for (int t = 0; t < 20 && !bus12.coeff_valid; t++) begin
            bus12.in_valid = (pos < 2);
            bus12.in_byte  = (pos < 2) ? b[pos] : 8'h00;
            #1;
            if (bus12.in_valid && bus12.in_ready) pos++;
            cyc();
        end
        bus12.in_valid = 1'b0;
        chk("bp_valid", {31'd0, bus12.coeff_valid}, 32'd1);
        for (int h = 0; h < 5; h++) begin
            start = (h == 2);
            #1;
            chk("bp_hold_out",   {20'd0, bus12.coeff_out},   32'h301);
            chk("bp_hold_idx",   {24'd0, bus12.coeff_idx},   32'd0);
            chk("bp_in_ready",   {31'd0, bus12.in_ready},    32'd0);
            chk("bp_hold_valid", {31'd0, bus12.coeff_valid}, 32'd1);
            cyc();
        end
        start = 1'b0;
        chk("bp_busy", {31'd0, busy12}, 32'd1);
        bus12.coeff_ready = 1'b1;
        cyc();
        bus12.coeff_ready = 1'b0;
        chk("bp_idx_next",  {24'd0, bus12.coeff_idx},   32'd1);
        chk("bp_ready_nxt", {31'd0, bus12.in_ready},    32'd1);
        chk("bp_valid_nxt", {31'd0, bus12.coeff_valid}, 32'd0);

        // Reset after 100 coefficients, then a clean full frame
        do_reset("rst_f");
        pulse_start();
        b = {};
        for (int i = 0; i < 150; i++) b.push_back(rnd_frame[i]);
        stream(b, 1'b1, 1'b0);
        chk("mid_busy", {31'd0, busy12}, 32'd1);
        chk("mid_idx",  {24'd0, bus12.coeff_idx}, 32'd100);
        do_reset("midrst");
        pulse_start();
        b = {};
        for (int i = 0; i < 384; i++) b.push_back(8'($urandom_range(0, 255)));
        stream(b, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/byte_decode_stream.md
Name: byte_decode_stream

Overview:
- Streaming ByteDecode_d stage for the Kyber-768-90s datapath.
- Consumes the little-endian bit stream produced by the byte-to-bit conversion, accepting it one byte per handshake.
- Emits 256 d-bit polynomial coefficients with a valid/ready handshake.
- Replaces the full-width combinational bit array with a small bit accumulator. It sits between the byte source (hash output or ciphertext/key buffer) and the polynomial RAM writer.

Parameters:
- D, 12, coefficient bit width; legal values 1, 4, 5, 10, 11, 12.
- N_COEFF, 256, coefficients per frame.
- Q, 3329, modulus; applied only when D == 12.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a frame when idle.
- in_byte  input  8  next input byte; bit j of the byte is stream bit 8*k+j.
- in_valid  input  1  in_byte valid.
- in_ready  output  1  byte accepted when in_valid && in_ready.
- coeff_out  output  12  decoded coefficient, zero-extended from D bits.
- coeff_idx  output  8  index (0..255) of coeff_out within the frame.
- coeff_valid  output  1  coeff_out valid.
- coeff_ready  input  1  consumer accepts when coeff_valid && coeff_ready.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse at end of frame.

Behaviour:
- Reset (async, any time, including mid-frame):
  - Returns to IDLE.
  - Clears accumulator, bit count and coefficient counter.
  - All outputs 0: in_ready, coeff_valid, busy, done, coeff_out, coeff_idx.
- States: IDLE, RUN, DONE.
  - IDLE: start=1 -> RUN; accumulator and counters cleared. start is ignored in RUN and DONE.
  - RUN: after the handshake of coefficient N_COEFF-1 -> DONE.
  - DONE: done=1 and busy=0 for exactly one cycle -> IDLE.
- Accumulator:
  - Register acc of D+7 bits and bit count cnt of 0..D+7.
  - LSB-first: an accepted byte is written to acc[cnt+7:cnt], then cnt += 8.
- in_ready = (state==RUN) && (cnt < D). It is a function of registers only, with no combinational path from coeff_ready.
- coeff_valid = (state==RUN) && (cnt >= D). It is never high in the same cycle as in_ready, so a byte accept and a coefficient emit never coincide.
- On a coefficient handshake: acc shifts right by D, cnt -= D, coeff_idx increments.
- coeff_out:
  - D==12: acc[11:0] reduced mod Q by a single conditional subtract (v >= Q ? v-Q : v). This is valid because 4095 < 2Q.
  - D<12: acc[D-1:0] zero-extended, no reduction.
- Holding: while coeff_valid && !coeff_ready, coeff_out and coeff_idx hold stable.
- Frame length: exactly 32*D bytes yield 256 coefficients with cnt==0 at frame end, so no leftover bits. Bytes beyond the frame are not accepted (in_ready=0 outside RUN).
- Throughput: one handshake per cycle on either side. For D=12 the steady state is 3 bytes -> 2 coefficients in 5 cycles. Latency from accept of the last needed byte to coeff_valid is 1 cycle.
- in_valid, in_byte, coeff_ready are don't-care outside RUN. The producer must hold in_byte stable while in_valid && !in_ready.

Test Plan:
- D=12: start, then bytes 0x01,0x23,0x45 -> coefficients 0x301 (idx 0), 0x452 (idx 1); in_ready low while 2nd coefficient pending.
- D=12 reduction: bytes 0xFF,0xFF,0xFF -> 766, 766; bytes 0x01,0x0D,0x00 -> 0 (3329 mod Q), 0.
- D=1 byte 0xA5 -> 1,0,1,0,0,1,0,1 at idx 0..7; D=4 byte 0x3C -> 0xC, 0x3.
- Full frame D=12: 384 random bytes with random in_valid/coeff_ready stalls -> 256 coefficients matching the software ByteDecode_12 model, idx 0..255 in order; done pulses once in the cycle after handshake 255; busy then 0; a 385th byte sees in_ready=0.
- Backpressure: coeff_ready held low 5 cycles with coeff_valid=1 -> coeff_out/coeff_idx stable, in_ready=0 throughout; start pulsed meanwhile is ignored.
- Reset mid-frame: assert rst after 100 coefficients -> all outputs 0 immediately; new start + 384 bytes -> coefficients restart at idx 0 with correct values.
